// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares a single memory port between the core (m0) and the debug module's
//   system-bus master (m1). One transaction is in flight at a time:
//   arbitrate in IDLE, present the address phase in ADDR, then return the
//   read response to the owner in RESP. Writes skip RESP.
//
// Parameters
//   ADDR_W         address width
//   DATA_W         data width
//   FIXED_PRIO     0 = round-robin between m0/m1, 1 = m1 wins whenever it requests
//   TIMEOUT_CYCLES response watchdog limit (only with MEM_ARB_TIMEOUT_EN)
//
// Optional build macro
//   MEM_ARB_TIMEOUT_EN  enables the RESP watchdog; on expiry the owner gets
//                       rvalid + err with rdata = 32'hDEAD_BEEF.
//                       Without it RESP waits forever and mX_err is 0.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   mX_req/addr/wdata/we/type/sign   master X request and transfer fields
//   mX_gnt                    pulse: address phase accepted by memory
//   mX_rvalid/rdata/err       read response (rdata is 0 outside rvalid)
//   core_stall                m0_req & ~m0_gnt
//   s_req/addr/wdata/we/type/sign    latched request towards memory
//   s_gnt, s_rvalid, s_rdata  memory handshake and read data
//
// State table
//   state | meaning
//   IDLE  | no transaction; arbitrate and latch the winner's fields
//   ADDR  | s_req asserted with latched fields, waiting for s_gnt
//   RESP  | read issued, waiting for s_rvalid (or watchdog expiry)

`timescale 1ns/1ps

module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_we,
    input  logic [1:0]        m0_type,
    input  logic              m0_sign,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_we,
    input  logic [1:0]        m1_type,
    input  logic              m1_sign,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,

    output logic              core_stall,

    output logic              s_req,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_we,
    output logic [1:0]        s_type,
    output logic              s_sign,
    input  logic              s_gnt,
    input  logic              s_rvalid,
    input  logic [DATA_W-1:0] s_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic              owner;       // 0 = m0, 1 = m1
    logic              last_owner;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [1:0]        type_q;
    logic              sign_q;

    logic              pick_m1;
    logic              expire;
    logic              gnt_pulse;
    logic              resp_done;
    logic [DATA_W-1:0] resp_data;

    // Winner selection. In round-robin mode a tie goes to whoever did not
    // own the previous transaction; a lone requester always wins.
    always_comb begin
        pick_m1 = 1'b0;
        if (FIXED_PRIO != 0) begin
            pick_m1 = m1_req;
        end else if (m0_req && m1_req) begin
            pick_m1 = ~last_owner;
        end else begin
            pick_m1 = m1_req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            type_q     <= 2'b00;
            sign_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        owner      <= pick_m1;
                        last_owner <= pick_m1;
                        addr_q     <= pick_m1 ? m1_addr  : m0_addr;
                        wdata_q    <= pick_m1 ? m1_wdata : m0_wdata;
                        we_q       <= pick_m1 ? m1_we    : m0_we;
                        type_q     <= pick_m1 ? m1_type  : m0_type;
                        sign_q     <= pick_m1 ? m1_sign  : m0_sign;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_gnt) begin
                        state <= we_q ? IDLE : RESP;
                    end
                end
                RESP: begin
                    if (s_rvalid || expire) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    // Down-counter loaded as the read is granted; expiry is the terminal
    // count while still in RESP. A same-cycle s_rvalid wins over expiry.
    logic [TMR_W-1:0] tmr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr <= '0;
        end else if (state == ADDR && s_gnt && !we_q) begin
            tmr <= TMR_W'(TIMEOUT_CYCLES);
        end else if (state == RESP && !s_rvalid && tmr != '0) begin
            tmr <= tmr - 1'b1;
        end
    end

    assign expire    = (state == RESP) && (tmr == '0);
    assign resp_data = s_rvalid ? s_rdata : DATA_W'(32'hDEAD_BEEF);
    assign m0_err    = resp_done && !s_rvalid && !owner;
    assign m1_err    = resp_done && !s_rvalid &&  owner;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign expire             = 1'b0;
    assign resp_data          = s_rdata;
    assign m0_err             = 1'b0;
    assign m1_err             = 1'b0;
`endif

    // Grant and response pulses follow the memory handshake combinationally
    // so the owner sees them in the same cycle as s_gnt / s_rvalid.
    assign gnt_pulse = (state == ADDR) && s_gnt;
    assign resp_done = (state == RESP) && (s_rvalid || expire);

    assign m0_gnt    = gnt_pulse && !owner;
    assign m1_gnt    = gnt_pulse &&  owner;
    assign m0_rvalid = resp_done && !owner;
    assign m1_rvalid = resp_done &&  owner;
    assign m0_rdata  = m0_rvalid ? resp_data : '0;
    assign m1_rdata  = m1_rvalid ? resp_data : '0;

    assign core_stall = m0_req && !m0_gnt;

    assign s_req   = (state == ADDR);
    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;
    assign s_we    = we_q;
    assign s_type  = type_q;
    assign s_sign  = sign_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        m0_req = 0, m0_we = 0, m0_sign = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0;
    logic [1:0]  m0_type = 0;
    logic        m1_req = 0, m1_we = 0, m1_sign = 0;
    logic [31:0] m1_addr = 0, m1_wdata = 0;
    logic [1:0]  m1_type = 0;
    logic        s_gnt = 0, s_rvalid = 0;
    logic [31:0] s_rdata = 0;

    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, core_stall;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we, s_sign;
    logic [31:0] s_addr, s_wdata;
    logic [1:0]  s_type;

    logic        f_m0_gnt, f_m0_rvalid, f_m0_err, f_m1_gnt, f_m1_rvalid, f_m1_err, f_core_stall;
    logic [31:0] f_m0_rdata, f_m1_rdata;
    logic        f_s_req, f_s_we, f_s_sign;
    logic [31:0] f_s_addr, f_s_wdata;
    logic [1:0]  f_s_type;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_type(m0_type), .m0_sign(m0_sign), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_type(m1_type), .m1_sign(m1_sign), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata), .m1_err(m1_err),
        .core_stall(core_stall),
        .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we),
        .s_type(s_type), .s_sign(s_sign), .s_gnt(s_gnt), .s_rvalid(s_rvalid),
        .s_rdata(s_rdata)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .TIMEOUT_CYCLES(4)) u_fix (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_type(m0_type), .m0_sign(m0_sign), .m0_gnt(f_m0_gnt), .m0_rvalid(f_m0_rvalid),
        .m0_rdata(f_m0_rdata), .m0_err(f_m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_type(m1_type), .m1_sign(m1_sign), .m1_gnt(f_m1_gnt), .m1_rvalid(f_m1_rvalid),
        .m1_rdata(f_m1_rdata), .m1_err(f_m1_err),
        .core_stall(f_core_stall),
        .s_req(f_s_req), .s_addr(f_s_addr), .s_wdata(f_s_wdata), .s_we(f_s_we),
        .s_type(f_s_type), .s_sign(f_s_sign), .s_gnt(s_gnt), .s_rvalid(s_rvalid),
        .s_rdata(s_rdata)
    );

    // Inputs change just after the falling edge; outputs are checked 1ns later.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, core_stall, s_req} !== 8'h00) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000000",
                     {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, core_stall, s_req});
        end
        checks++;
        if ({s_addr, s_wdata, s_we, s_type, s_sign, m0_rdata, m1_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_fields s_addr=%h s_wdata=%h m0_rdata=%h m1_rdata=%h exp=0",
                     s_addr, s_wdata, m0_rdata, m1_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_read();
        tick();
        m0_req = 1; m0_addr = 32'h100; m0_we = 0; m0_type = 2'b10; s_gnt = 1;
        #1;
        checks++;
        if (s_req !== 1'b0 || m0_gnt !== 1'b0 || core_stall !== 1'b1) begin
            failures++;
            $display("FAIL rd_c0 s_req=%b m0_gnt=%b stall=%b exp=0,0,1", s_req, m0_gnt, core_stall);
        end
        tick(); #1;
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h100 || s_type !== 2'b10 || m0_gnt !== 1'b1 || core_stall !== 1'b0) begin
            failures++;
            $display("FAIL rd_c1 s_req=%b s_addr=%h s_type=%b m0_gnt=%b stall=%b exp=1,100,10,1,0",
                     s_req, s_addr, s_type, m0_gnt, core_stall);
        end
        m0_req = 0;
        tick();
        s_gnt = 0; s_rvalid = 1; s_rdata = 32'h1234_5678;
        #1;
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h1234_5678 || m0_err !== 1'b0) begin
            failures++;
            $display("FAIL rd_c2 m0_rvalid=%b m0_rdata=%h m0_err=%b exp=1,12345678,0", m0_rvalid, m0_rdata, m0_err);
        end
        checks++;
        if (m1_rvalid !== 1'b0 || m1_gnt !== 1'b0 || m1_rdata !== 32'h0 || m1_err !== 1'b0) begin
            failures++;
            $display("FAIL rd_m1_quiet rvalid=%b gnt=%b rdata=%h err=%b exp=0", m1_rvalid, m1_gnt, m1_rdata, m1_err);
        end
        tick();
        s_rvalid = 0;
        #1;
        checks++;
        if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0 || s_req !== 1'b0) begin
            failures++;
            $display("FAIL rd_c3 m0_rvalid=%b m0_rdata=%h s_req=%b exp=0,0,0", m0_rvalid, m0_rdata, s_req);
        end
    endtask

    task automatic test_arbitration();
        int phase;
        int own;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_req = 1; m0_addr = 32'h400; m1_req = 1; m1_addr = 32'h800;
        m0_we = 0; m1_we = 0; s_gnt = 1; s_rvalid = 1;
        // Every transaction is IDLE, ADDR (gnt), RESP (rvalid); ties alternate.
        for (int i = 0; i < 12; i++) begin
            s_rdata = 32'h1000_0000 + i;
            #1;
            phase = i % 3;
            own   = (i / 3) % 2;
            checks++;
            if (m0_gnt !== (phase == 1 && own == 0) || m1_gnt !== (phase == 1 && own == 1)) begin
                failures++;
                $display("FAIL rr_gnt cyc=%0d m0_gnt=%b m1_gnt=%b exp=%b,%b", i, m0_gnt, m1_gnt,
                         (phase == 1 && own == 0), (phase == 1 && own == 1));
            end
            checks++;
            if (m0_rvalid !== (phase == 2 && own == 0) || m1_rvalid !== (phase == 2 && own == 1)) begin
                failures++;
                $display("FAIL rr_rvalid cyc=%0d m0_rvalid=%b m1_rvalid=%b exp=%b,%b", i, m0_rvalid, m1_rvalid,
                         (phase == 2 && own == 0), (phase == 2 && own == 1));
            end
            if (phase == 1) begin
                checks++;
                if (s_addr !== (own == 1 ? 32'h800 : 32'h400) || core_stall !== (own == 1)) begin
                    failures++;
                    $display("FAIL rr_addr cyc=%0d s_addr=%h stall=%b exp=%h,%b", i, s_addr, core_stall,
                             (own == 1 ? 32'h800 : 32'h400), (own == 1));
                end
            end
            if (phase == 2) begin
                checks++;
                if ((own == 0 ? m0_rdata : m1_rdata) !== 32'h1000_0000 + i) begin
                    failures++;
                    $display("FAIL rr_rdata cyc=%0d got=%h exp=%h", i, (own == 0 ? m0_rdata : m1_rdata), 32'h1000_0000 + i);
                end
            end
            checks++;
            if (f_m0_gnt !== 1'b0 || f_m1_gnt !== (phase == 1) || f_core_stall !== 1'b1 || f_m0_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL fixed_prio cyc=%0d m0_gnt=%b m1_gnt=%b stall=%b m0_rvalid=%b exp=0,%b,1,0",
                         i, f_m0_gnt, f_m1_gnt, f_core_stall, f_m0_rvalid, (phase == 1));
            end
            tick();
        end
        m0_req = 0; m1_req = 0; s_gnt = 0; s_rvalid = 0;
    endtask

    task automatic test_write_wait();
        m1_req = 1; m1_addr = 32'h2000; m1_wdata = 32'hCAFE_F00D; m1_we = 1; m1_type = 2'b10; m1_sign = 0;
        #1;
        checks++;
        if (s_req !== 1'b0) begin
            failures++;
            $display("FAIL wr_c0 s_req=%b exp=0", s_req);
        end
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 2) m1_req = 0;
            if (c == 3) begin
                m0_req = 1; m0_addr = 32'h300; m0_we = 0; m0_type = 2'b01; m0_sign = 1;
            end
            #1;
            checks++;
            if (s_req !== 1'b1 || s_addr !== 32'h2000 || s_wdata !== 32'hCAFE_F00D || s_we !== 1'b1 || m1_gnt !== 1'b0) begin
                failures++;
                $display("FAIL wr_hold c=%0d s_req=%b s_addr=%h s_wdata=%h s_we=%b m1_gnt=%b exp=1,2000,cafef00d,1,0",
                         c, s_req, s_addr, s_wdata, s_we, m1_gnt);
            end
        end
        tick();
        s_gnt = 1;
        #1;
        checks++;
        if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || s_req !== 1'b1 || core_stall !== 1'b1) begin
            failures++;
            $display("FAIL wr_gnt m1_gnt=%b m0_gnt=%b s_req=%b stall=%b exp=1,0,1,1", m1_gnt, m0_gnt, s_req, core_stall);
        end
        tick();
        s_gnt = 0; s_rvalid = 1; s_rdata = 32'hBAD0_0001;
        #1;
        checks++;
        if (s_req !== 1'b0 || m1_rvalid !== 1'b0 || m0_rvalid !== 1'b0 || core_stall !== 1'b1) begin
            failures++;
            $display("FAIL wr_idle s_req=%b m1_rvalid=%b m0_rvalid=%b stall=%b exp=0,0,0,1", s_req, m1_rvalid, m0_rvalid, core_stall);
        end
        tick();
        s_gnt = 1;
        #1;
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h300 || s_type !== 2'b01 || s_sign !== 1'b1 || s_we !== 1'b0 ||
            m0_gnt !== 1'b1 || m0_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL wait_addr s_req=%b s_addr=%h s_type=%b s_sign=%b s_we=%b m0_gnt=%b m0_rvalid=%b exp=1,300,01,1,0,1,0",
                     s_req, s_addr, s_type, s_sign, s_we, m0_gnt, m0_rvalid);
        end
        tick();
        m0_req = 0; s_gnt = 0; s_rdata = 32'h7654_3210;
        #1;
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h7654_3210 || m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin
            failures++;
            $display("FAIL wait_resp m0_rvalid=%b m0_rdata=%h m1_rvalid=%b m1_rdata=%h exp=1,76543210,0,0",
                     m0_rvalid, m0_rdata, m1_rvalid, m1_rdata);
        end
        tick();
        s_rvalid = 0; m1_we = 0; m0_sign = 0; m0_type = 2'b10;
        #1;
        checks++;
        if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0 || s_req !== 1'b0) begin
            failures++;
            $display("FAIL wait_done m0_rvalid=%b m0_rdata=%h s_req=%b exp=0,0,0", m0_rvalid, m0_rdata, s_req);
        end
    endtask

    task automatic test_reset_in_resp();
        tick();
        m0_req = 1; m0_addr = 32'h500; m0_we = 0; s_gnt = 1; s_rvalid = 0;
        tick(); #1;
        checks++;
        if (m0_gnt !== 1'b1) begin
            failures++;
            $display("FAIL rr_setup_gnt m0_gnt=%b exp=1", m0_gnt);
        end
        m0_req = 0;
        tick();
        s_gnt = 0;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, core_stall, s_req, s_we, s_sign} !== 10'h0 ||
            s_addr !== 32'h0 || s_type !== 2'b00 || m0_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_resp ctrl=%b s_addr=%h s_type=%b m0_rdata=%h exp=0",
                     {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, core_stall, s_req, s_we, s_sign},
                     s_addr, s_type, m0_rdata);
        end
        tick();
        rst = 1'b0; s_rvalid = 1; s_rdata = 32'hFFFF_0000;
        #1;
        checks++;
        if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0 || m1_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL stale_rvalid m0_rvalid=%b m0_rdata=%h m1_rvalid=%b exp=0,0,0", m0_rvalid, m0_rdata, m1_rvalid);
        end
        tick();
        s_rvalid = 0; m0_req = 1; m1_req = 1; m0_addr = 32'h600; m1_addr = 32'h700; s_gnt = 1;
        tick(); #1;
        checks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || s_addr !== 32'h600) begin
            failures++;
            $display("FAIL post_rst_tie m0_gnt=%b m1_gnt=%b s_addr=%h exp=1,0,600", m0_gnt, m1_gnt, s_addr);
        end
        m0_req = 0; m1_req = 0;
        tick();
        s_gnt = 0; s_rvalid = 1; s_rdata = 32'h0600_0600;
        #1;
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0600_0600) begin
            failures++;
            $display("FAIL post_rst_rd m0_rvalid=%b m0_rdata=%h exp=1,06000600", m0_rvalid, m0_rdata);
        end
        tick();
        s_rvalid = 0;
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout(input logic hit_expiry);
        tick();
        m0_req = 1; m0_addr = 32'h900; m0_we = 0; s_gnt = 1; s_rvalid = 0;
        tick();
        m0_req = 0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            s_gnt = 0;
            #1;
            checks++;
            if (m0_rvalid !== 1'b0 || m0_err !== 1'b0) begin
                failures++;
                $display("FAIL to_wait c=%0d m0_rvalid=%b m0_err=%b exp=0,0", c, m0_rvalid, m0_err);
            end
        end
        tick();
        if (hit_expiry) begin
            s_rvalid = 1; s_rdata = 32'h5555_AAAA;
        end
        #1;
        checks++;
        if (hit_expiry) begin
            if (m0_rvalid !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'h5555_AAAA) begin
                failures++;
                $display("FAIL to_race m0_rvalid=%b m0_err=%b m0_rdata=%h exp=1,0,5555aaaa", m0_rvalid, m0_err, m0_rdata);
            end
        end else begin
            if (m0_rvalid !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF || m1_rvalid !== 1'b0 || m1_err !== 1'b0) begin
                failures++;
                $display("FAIL to_expire m0_rvalid=%b m0_err=%b m0_rdata=%h m1_rvalid=%b m1_err=%b exp=1,1,deadbeef,0,0",
                         m0_rvalid, m0_err, m0_rdata, m1_rvalid, m1_err);
            end
        end
        tick();
        s_rvalid = 1; s_rdata = 32'h0000_1111;
        #1;
        checks++;
        if (m0_rvalid !== 1'b0 || m0_err !== 1'b0 || m0_rdata !== 32'h0) begin
            failures++;
            $display("FAIL to_late m0_rvalid=%b m0_err=%b m0_rdata=%h exp=0,0,0", m0_rvalid, m0_err, m0_rdata);
        end
        tick();
        s_rvalid = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_read();
        test_arbitration();
        test_write_wait();
        test_reset_in_resp();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout(1'b0);
        test_timeout(1'b1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
